// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, branch flush, data-memory stall with timeout abort.
// Zero latency: all controls decode combinationally from the current state and inputs.
// Backpressure: a pending memory access freezes the whole pipe until mem_ack_i or MEM_TIMEOUT.
// Optional HAZ_PERF_CNT_EN adds saturating stall-cycle and flush counters.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       ID_EX_MemRead,
    input  logic [4:0] ID_EX_RegisterRt,
    input  logic [4:0] IF_ID_RegisterRs,
    input  logic [4:0] IF_ID_RegisterRt,
    input  logic       Branch_taken,
    input  logic       EX_MEM_MemReq,
    input  logic       mem_ack_i,
    output logic       PC_Write,
    output logic       IF_ID_Write,
    output logic       ID_EX_Bubble,
    output logic       IF_ID_Flush,
    output logic       Pipe_Freeze,
    output logic       mem_err_o,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0] stall_cycles_o,
    output logic [15:0] flush_cnt_o,
`endif
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN      = 2'b01,
        MEM_WAIT = 2'b10,
        ABORT    = 2'b11
    } state_t;

    localparam logic [7:0] TIMEOUT_C = MEM_TIMEOUT[7:0];

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       load_use;
    logic       mem_hold;

    assign load_use = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                      ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                       (ID_EX_RegisterRt == IF_ID_RegisterRt));

    // In MEM_WAIT the access is already outstanding, so only the ack matters.
    assign mem_hold = (state_q == RUN) ? (EX_MEM_MemReq && !mem_ack_i) : !mem_ack_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = 8'd0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            RUN: begin
                if (mem_hold) begin
                    state_d = MEM_WAIT;
                    cnt_d   = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i) begin
                    state_d = RUN;
                end else begin
                    if (cnt_q == TIMEOUT_C) state_d = ABORT;
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced to IDLE values while reset is asserted, whatever the state.
    always_comb begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        Pipe_Freeze  = 1'b1;
        mem_err_o    = 1'b0;
        if (rst_i) begin
            case (state_q)
                RUN, MEM_WAIT: begin
                    if (!mem_hold) begin
                        Pipe_Freeze = 1'b0;
                        if (load_use) begin
                            ID_EX_Bubble = 1'b1;
                        end else begin
                            PC_Write    = 1'b1;
                            IF_ID_Write = 1'b1;
                            IF_ID_Flush = Branch_taken;
                        end
                    end
                end
                ABORT:   mem_err_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_o = rst_i ? state_q : IDLE;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_q <= 32'd0;
            flush_q <= 16'd0;
        end else begin
            if ((state_q != IDLE) && !PC_Write && (stall_q != 32'hFFFF_FFFF))
                stall_q <= stall_q + 32'd1;
            if (IF_ID_Flush && (flush_q != 16'hFFFF))
                flush_q <= flush_q + 16'd1;
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_cnt_o    = flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;
    localparam int TMO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, memread, br, req, ack;
    logic [4:0] ex_rt, id_rs, id_rt;
    logic       pc_w, ifid_w, bubble, flush, freeze, err;
    logic [1:0] state;
    logic [7:0] dut_vec;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: 0 idle, 1 run, 2 waiting on memory, 3 abort.
    int ms = 0;
    int waited = 0;
    int m_stall = 0;
    int m_flush = 0;

    hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .start_i          (start),
        .ID_EX_MemRead    (memread),
        .ID_EX_RegisterRt (ex_rt),
        .IF_ID_RegisterRs (id_rs),
        .IF_ID_RegisterRt (id_rt),
        .Branch_taken     (br),
        .EX_MEM_MemReq    (req),
        .mem_ack_i        (ack),
        .PC_Write         (pc_w),
        .IF_ID_Write      (ifid_w),
        .ID_EX_Bubble     (bubble),
        .IF_ID_Flush      (flush),
        .Pipe_Freeze      (freeze),
        .mem_err_o        (err),
`ifdef HAZ_PERF_CNT_EN
        .stall_cycles_o   (stall_cnt),
        .flush_cnt_o      (flush_cnt),
`endif
        .state_o          (state)
    );

    assign dut_vec = {state, pc_w, ifid_w, bubble, flush, freeze, err};

    // Expected {state, PC_Write, IF_ID_Write, Bubble, Flush, Freeze, err} for this cycle.
    function automatic logic [7:0] model_out();
        logic [1:0] st;
        logic hold, lu;
        if (!rst_n || ms == 0) return 8'b00_000010;
        if (ms == 3) return 8'b11_000011;
        st   = 2'(ms);
        hold = (ms == 1) ? (req && !ack) : !ack;
        lu   = memread && ex_rt != 5'd0 && (ex_rt == id_rs || ex_rt == id_rt);
        if (hold) return {st, 6'b000010};
        if (lu)   return {st, 6'b001000};
        return {st, 2'b11, 1'b0, br, 2'b00};
    endfunction

    task automatic model_advance();
        logic [7:0] e;
        e = model_out();
        if (!rst_n) begin
            ms = 0; waited = 0; m_stall = 0; m_flush = 0;
            return;
        end
        if (ms != 0 && !e[5]) m_stall++;
        if (e[2] && m_flush < 65535) m_flush++;
        case (ms)
            0: if (start) ms = 1;
            1: if (req && !ack) begin ms = 2; waited = 0; end
            2: if (ack) ms = 1;
               else begin
                   waited++;
                   if (waited == TMO) ms = 3;
               end
            default: ms = 0;
        endcase
    endtask

    task automatic clear_inputs();
        rst_n = 1'b1; start = 1'b0; memread = 1'b0; br = 1'b0; req = 1'b0; ack = 1'b0;
        ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    endtask

    task automatic test_reset();
        logic [7:0] exp, got;
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            if (i < 2) begin
                rst_n = 1'b0; start = 1'b1; ack = 1'(i); req = 1'b1;
                memread = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; br = 1'b1;
            end else if (i == 2) begin
                start = 1'b1;
            end
            @(negedge clk);
            exp = model_out(); got = dut_vec; n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL reset_model[%0d] got=%b exp=%b", i, got, exp); end
            if (i <= 2) begin
                n_cmp++;
                if (got !== 8'b00_000010) begin n_bad++; $display("FAIL reset_idle[%0d] got=%b exp=00000010", i, got); end
            end else begin
                n_cmp++;
                if (got[7:5] !== 3'b011) begin n_bad++; $display("FAIL reset_start_run got=%b exp=011", got[7:5]); end
            end
            @(posedge clk); model_advance(); #1;
        end
    endtask

    task automatic test_load_use();
        logic [7:0] exp, got, chk;
        bit has_chk;
        for (int i = 0; i < 6; i++) begin
            clear_inputs(); has_chk = 0; chk = '0;
            case (i)
                0: rst_n = 1'b0;
                1: start = 1'b1;
                2: begin memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; br = 1'b1; has_chk = 1; chk = 8'b01_001000; end
                3: begin memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; br = 1'b1; has_chk = 1; chk = 8'b01_110100; end
                4: begin memread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd1; has_chk = 1; chk = 8'b01_001000; end
                default: begin memread = 1'b1; ex_rt = 5'd7; id_rs = 5'd6; id_rt = 5'd8; end
            endcase
            @(negedge clk);
            exp = model_out(); got = dut_vec; n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL load_use_model[%0d] got=%b exp=%b", i, got, exp); end
            if (has_chk) begin
                n_cmp++;
                if (got !== chk) begin n_bad++; $display("FAIL load_use_fixed[%0d] got=%b exp=%b", i, got, chk); end
            end
            @(posedge clk); model_advance(); #1;
        end
    endtask

    task automatic test_mem_wait();
        logic [7:0] exp, got;
        int frz;
        frz = 0;
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            case (i)
                0: rst_n = 1'b0;
                1: start = 1'b1;
                2, 3, 4, 5: req = 1'b1;
                6: begin req = 1'b1; ack = 1'b1; end
                default: ;
            endcase
            @(negedge clk);
            exp = model_out(); got = dut_vec; n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL mem_wait_model[%0d] got=%b exp=%b", i, got, exp); end
            if (i >= 2 && i <= 6 && got[1] === 1'b1) frz++;
            if (i == 6) begin
                n_cmp++;
                if (got !== 8'b10_110000) begin n_bad++; $display("FAIL mem_wait_release got=%b exp=10110000", got); end
            end
            if (i == 7) begin
                n_cmp++;
                if (got[7:6] !== 2'b01) begin n_bad++; $display("FAIL mem_wait_back_to_run got=%b exp=01", got[7:6]); end
            end
            @(posedge clk); model_advance(); #1;
        end
        n_cmp++;
        if (frz != 4) begin n_bad++; $display("FAIL mem_wait_freeze_cycles got=%0d exp=4", frz); end
    endtask

    task automatic test_timeout();
        logic [7:0] exp, got;
        int errs;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            clear_inputs();
            if (i == 0) rst_n = 1'b0;
            else start = 1'b1;
            if (i >= 2 && i <= 8) req = 1'b1;
            @(negedge clk);
            exp = model_out(); got = dut_vec; n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL timeout_model[%0d] got=%b exp=%b", i, got, exp); end
            if (got[0] === 1'b1) errs++;
            if (i == 7) begin
                n_cmp++;
                if (got !== 8'b11_000011) begin n_bad++; $display("FAIL timeout_abort got=%b exp=11000011", got); end
            end
            if (i == 8) begin
                n_cmp++;
                if (got !== 8'b00_000010) begin n_bad++; $display("FAIL timeout_idle got=%b exp=00000010", got); end
            end
            @(posedge clk); model_advance(); #1;
        end
        n_cmp++;
        if (errs != 1) begin n_bad++; $display("FAIL timeout_err_pulses got=%0d exp=1", errs); end
    endtask

    task automatic test_reset_in_wait();
        logic [7:0] exp, got;
        for (int i = 0; i < 7; i++) begin
            clear_inputs();
            case (i)
                0: rst_n = 1'b0;
                1: start = 1'b1;
                2, 3: req = 1'b1;
                4: begin rst_n = 1'b0; req = 1'b1; ack = 1'b1; end
                default: begin req = 1'b1; ack = 1'b1; end
            endcase
            @(negedge clk);
            exp = model_out(); got = dut_vec; n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL rst_wait_model[%0d] got=%b exp=%b", i, got, exp); end
            if (i >= 4) begin
                n_cmp++;
                if (got !== 8'b00_000010) begin n_bad++; $display("FAIL rst_wait_idle[%0d] got=%b exp=00000010", i, got); end
            end
            @(posedge clk); model_advance(); #1;
        end
    endtask

    task automatic test_random();
        logic [7:0] exp, got;
        for (int i = 0; i < 800; i++) begin
            rst_n   = ($urandom_range(0, 59) != 0);
            start   = ($urandom_range(0, 3) != 0);
            memread = 1'($urandom_range(0, 1));
            ex_rt   = 5'($urandom_range(0, 3));
            id_rs   = 5'($urandom_range(0, 3));
            id_rt   = 5'($urandom_range(0, 3));
            br      = 1'($urandom_range(0, 1));
            req     = ($urandom_range(0, 2) == 0);
            ack     = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            exp = model_out(); got = dut_vec; n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL random[%0d] got=%b exp=%b", i, got, exp); end
`ifdef HAZ_PERF_CNT_EN
            n_cmp++;
            if (stall_cnt !== 32'(m_stall) || flush_cnt !== 16'(m_flush)) begin
                n_bad++;
                $display("FAIL random_perf[%0d] got=%0d/%0d exp=%0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush);
            end
`endif
            @(posedge clk); model_advance(); #1;
        end
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic test_perf();
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            case (i)
                0: rst_n = 1'b0;
                1: start = 1'b1;
                2, 3: begin memread = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; end
                4: br = 1'b1;
                default: ;
            endcase
            @(negedge clk);
            if (i == 5) begin
                n_cmp++;
                if (stall_cnt !== 32'd2 || flush_cnt !== 16'd1) begin
                    n_bad++;
                    $display("FAIL perf_counts got=%0d/%0d exp=2/1", stall_cnt, flush_cnt);
                end
            end
            @(posedge clk); model_advance(); #1;
        end
    endtask
`endif

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_reset_in_wait();
`ifdef HAZ_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter: MEM_TIMEOUT, 16, max MEM_WAIT cycles before abort (2..255).
REQ-002 SHALL have port: clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_i  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start_i  in  1  level; leaves IDLE when high.
REQ-005 SHALL have ports: ID_EX_MemRead in 1, ID_EX_RegisterRt in 5; load in EX and its destination.
REQ-006 SHALL have ports: IF_ID_RegisterRs in 5, IF_ID_RegisterRt in 5; source registers of instruction in ID.
REQ-007 SHALL have ports: Branch_taken in 1 (ID resolves taken branch/jump); EX_MEM_MemReq in 1 (data-memory access in MEM); mem_ack_i in 1 (data memory done).
REQ-008 SHALL have outputs (all 1 bit): PC_Write; IF_ID_Write; ID_EX_Bubble (zero ID/EX controls); IF_ID_Flush; Pipe_Freeze (hold ID/EX, EX/MEM, MEM/WB); mem_err_o (one-cycle timeout pulse).
REQ-009 SHALL have output: state_o  out  2  current state encoding.

Function
REQ-010 SHALL implement FSM states IDLE=00, RUN=01, MEM_WAIT=10, ABORT=11.
REQ-011 SHALL set outputs combinationally from current state and current inputs (zero added latency).
REQ-012 IDLE: PC_Write=0, IF_ID_Write=0, Pipe_Freeze=1, others 0; start_i=1 -> RUN next cycle.
REQ-013 RUN, memory stall (EX_MEM_MemReq=1 and mem_ack_i=0): PC_Write=0, IF_ID_Write=0, Pipe_Freeze=1, ID_EX_Bubble=0, IF_ID_Flush=0; next MEM_WAIT, timeout counter loaded 1.
REQ-014 RUN, load-use (ID_EX_MemRead=1, ID_EX_RegisterRt!=0, Rt equals IF_ID_RegisterRs or IF_ID_RegisterRt), no memory stall: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; Branch_taken ignored this cycle; stay RUN.
REQ-015 RUN, Branch_taken=1, no memory stall, no load-use: IF_ID_Flush=1, PC_Write=1, IF_ID_Write=1; stay RUN.
REQ-016 RUN, none of the above: PC_Write=1, IF_ID_Write=1, others 0.
REQ-017 Priority SHALL be memory stall > load-use > branch flush.
REQ-018 MEM_WAIT, mem_ack_i=0: full freeze as REQ-013, counter increments; on counter==MEM_TIMEOUT -> ABORT next cycle.
REQ-019 MEM_WAIT, mem_ack_i=1: freeze released same cycle, outputs per REQ-014..016 evaluated that cycle, next RUN, counter cleared.
REQ-020 ABORT: mem_err_o=1 for exactly that cycle, full freeze, next IDLE; start_i still high -> IDLE holds one cycle then RUN.
REQ-021 Counter SHALL be 8 bits, saturating; never wraps.
REQ-022 start_i deassertion SHALL be ignored outside IDLE.
REQ-023 Register 0 as load destination SHALL never cause a stall.

Reset
REQ-024 rst_i=0 at a rising edge SHALL force IDLE, counter 0, mem_err_o 0, from any state including MEM_WAIT.
REQ-025 During and immediately after reset outputs SHALL equal IDLE values: PC_Write=0, IF_ID_Write=0, Pipe_Freeze=1, ID_EX_Bubble=0, IF_ID_Flush=0, mem_err_o=0, state_o=00.
REQ-026 Reset SHALL override start_i and mem_ack_i.

Configuration
REQ-027 Macro HAZ_PERF_CNT_EN defined: SHALL add outputs stall_cycles_o [31:0] (increments each cycle PC_Write=0 outside IDLE) and flush_cnt_o [15:0] (increments each IF_ID_Flush=1 cycle), both saturating, cleared by reset.
REQ-028 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset then start_i=1 one cycle -> IDLE outputs during reset, state_o=01 next cycle, PC_Write=1.
REQ-030 RUN, ID_EX_MemRead=1, ID_EX_RegisterRt=5, IF_ID_RegisterRs=5, Branch_taken=1 -> PC_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0; with Rt=0 -> no stall, IF_ID_Flush=1.
REQ-031 EX_MEM_MemReq=1, mem_ack_i low 3 cycles then high -> Pipe_Freeze=1 for 4 cycles incl. entry, released on ack cycle, state RUN after.
REQ-032 MEM_TIMEOUT=4, mem_ack_i never asserted -> ABORT after 4 MEM_WAIT cycles, mem_err_o single-cycle pulse, then IDLE.
REQ-033 rst_i=0 in MEM_WAIT -> next cycle state_o=00, Pipe_Freeze=1, counter cleared; late mem_ack_i ignored.
REQ-034 With HAZ_PERF_CNT_EN: two load-use stalls plus one branch flush -> stall_cycles_o=2, flush_cnt_o=1.
